// File: rtl/mux_scan_sel_pkg.sv
// Shared constants and helpers for the mux_scan_sel channel selector.
package mux_scan_pkg;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_AUTO   = 1'b1;

  // Widest one-hot vector the helper can build; N must not exceed this.
  localparam int unsigned ONEHOT_MAX = 64;

  function automatic logic [ONEHOT_MAX-1:0] onehot(input int unsigned idx,
                                                   input int unsigned n);
    logic [ONEHOT_MAX-1:0] v;
    v = '0;
    if (idx < n && idx < ONEHOT_MAX) v[idx] = 1'b1;
    return v;
  endfunction

  // Out-of-range selects map onto the last channel.
  function automatic int unsigned clamp_sel(input int unsigned sel,
                                            input int unsigned n);
    return (sel < n) ? sel : n - 1;
  endfunction

endpackage

// File: rtl/mux_scan_sel_scan_tick_gen.sv
// Dwell counter for auto-scan: pulses tick on the last cycle of each dwell.
module scan_tick_gen
  #(
    parameter int unsigned DWELL = 50000000
  )
  (
    input  logic clk,
    input  logic en,
    input  logic hold,
    input  logic clear,
    output logic tick
  );

  localparam int unsigned CW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

  logic [CW-1:0] cnt;

  assign tick = en && !hold && (cnt == LAST);

  // Count 0..DWELL-1 while enabled; hold freezes, disable or clear zeroes.
  always_ff @(posedge clk) begin
    if (clear || !en) begin
      cnt <= '0;
    end else if (!hold) begin
      if (cnt == LAST) cnt <= '0;
      else             cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mux_scan_sel.sv
// N-channel, W-bit registered multiplexer with manual select and auto-scan.
// Optional channel mask enabled by defining MUX_SCAN_MASK_EN.
module mux_scan_sel
  import mux_scan_pkg::*;
  #(
    parameter  int unsigned N     = 5,
    parameter  int unsigned W     = 3,
    parameter  int unsigned DWELL = 50000000,
    localparam int unsigned SELW  = $clog2(N)
  )
  (
    input  logic            CLK,
    input  logic            RST,
    input  logic [N*W-1:0]  DIN,
    input  logic [SELW-1:0] SEL,
    input  logic            MODE,
    input  logic            HOLD,
`ifdef MUX_SCAN_MASK_EN
    input  logic [N-1:0]    CH_MASK,
`endif
    output logic [W-1:0]    DOUT,
    output logic [SELW-1:0] CH,
    output logic [N-1:0]    CH_OH,
    output logic            CHG
  );

  logic            tick;
  logic [N-1:0]    mask;
  logic [SELW-1:0] ch_step;
  logic [SELW-1:0] ch_next;
  logic [N-1:0]    oh_next;
  logic [W-1:0]    dout_next;

`ifdef MUX_SCAN_MASK_EN
  assign mask = CH_MASK;
`else
  assign mask = '1;
`endif

  scan_tick_gen #(.DWELL(DWELL)) u_tick (
    .clk   (CLK),
    .en    (MODE == MODE_AUTO),
    .hold  (HOLD),
    .clear (RST),
    .tick  (tick)
  );

  // Next-channel selection: clamped SEL in manual, masked round-robin step in auto.
  always_comb begin
    logic        found;
    int unsigned idx;
    ch_step = CH;
    found   = 1'b0;
    // Search CH+1, CH+2, ... wrapping back to CH itself; no hit leaves CH.
    for (int unsigned k = 1; k <= N; k++) begin
      idx = (32'(CH) + k) % N;
      if (!found && mask[idx]) begin
        ch_step = SELW'(idx);
        found   = 1'b1;
      end
    end

    if (MODE == MODE_MANUAL) ch_next = SELW'(clamp_sel(32'(SEL), N));
    else if (tick)           ch_next = ch_step;
    else                     ch_next = CH;

    oh_next   = N'(onehot(32'(ch_next), N));
    dout_next = mask[ch_next] ? DIN[32'(ch_next)*W +: W] : '0;
  end

  // Output registers; CH and DOUT always refer to the same channel.
  always_ff @(posedge CLK) begin
    if (RST) begin
      DOUT  <= '0;
      CH    <= '0;
      CH_OH <= N'(1);
      CHG   <= 1'b0;
    end else begin
      DOUT  <= dout_next;
      CH    <= ch_next;
      CH_OH <= oh_next;
      CHG   <= (ch_next != CH);
    end
  end

endmodule

// File: tb/tb_mux_scan_sel.sv
// Self-checking bench for mux_scan_sel (N=5, W=3, DWELL=4).
module tb_mux_scan_sel;

  localparam int N     = 5;
  localparam int W     = 3;
  localparam int DWELL = 4;
  localparam int SELW  = 3;

  logic            CLK = 1'b0;
  logic            RST;
  logic [N*W-1:0]  DIN;
  logic [SELW-1:0] SEL;
  logic            MODE;
  logic            HOLD;
`ifdef MUX_SCAN_MASK_EN
  logic [N-1:0]    CH_MASK;
`endif
  logic [W-1:0]    DOUT;
  logic [SELW-1:0] CH;
  logic [N-1:0]    CH_OH;
  logic            CHG;

  mux_scan_sel #(.N(N), .W(W), .DWELL(DWELL)) dut (
    .CLK     (CLK),
    .RST     (RST),
    .DIN     (DIN),
    .SEL     (SEL),
    .MODE    (MODE),
    .HOLD    (HOLD),
`ifdef MUX_SCAN_MASK_EN
    .CH_MASK (CH_MASK),
`endif
    .DOUT    (DOUT),
    .CH      (CH),
    .CH_OH   (CH_OH),
    .CHG     (CHG)
  );

  always #5 CLK = ~CLK;

  int chan [N];
  int m_ch, m_cnt;
  int checks = 0, errors = 0;

  typedef struct {
    bit rst; bit mode; int sel; bit hold;
    int ch;  int dout; int chg;
  } vec_t;
  vec_t tbl [10];

  function void chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endfunction

  function int is_en(input int i);
`ifdef MUX_SCAN_MASK_EN
    return int'(CH_MASK[i]);
`else
    return 1;
`endif
  endfunction

  // Reference model: applies the selection rules to the inputs present at
  // the coming edge, then checks every output after the edge.
  task cycle(input string tag);
    int nch, ndout, nchg;
    bit found;
    for (int i = 0; i < N; i++) DIN[i*W +: W] = W'(chan[i]);
    if (RST) begin
      nch = 0; m_cnt = 0;
    end else if (MODE == 1'b0) begin
      nch = (int'(SEL) < N) ? int'(SEL) : N - 1;
      m_cnt = 0;
    end else if (HOLD) begin
      nch = m_ch;
    end else if (m_cnt == DWELL - 1) begin
      m_cnt = 0; nch = m_ch; found = 0;
      for (int k = 1; k <= N; k++)
        if (!found && is_en((m_ch + k) % N) != 0) begin
          nch = (m_ch + k) % N; found = 1;
        end
    end else begin
      m_cnt++; nch = m_ch;
    end
    if (RST) begin
      ndout = 0; nchg = 0;
    end else begin
      ndout = (is_en(nch) != 0) ? chan[nch] : 0;
      nchg  = (nch != m_ch) ? 1 : 0;
    end
    m_ch = nch;
    @(posedge CLK); #1;
    chk({tag, " CH"},    int'(CH),    m_ch);
    chk({tag, " DOUT"},  int'(DOUT),  ndout);
    chk({tag, " CH_OH"}, int'(CH_OH), 1 << m_ch);
    chk({tag, " CHG"},   int'(CHG),   nchg);
  endtask

  task chk_state(input string tag, input int ch, input int dout, input int chg);
    chk({tag, " ch"},   int'(CH),    ch);
    chk({tag, " dout"}, int'(DOUT),  dout);
    chk({tag, " oh"},   int'(CH_OH), 1 << ch);
    chk({tag, " chg"},  int'(CHG),   chg);
  endtask

  initial begin
    for (int i = 0; i < N; i++) chan[i] = i + 1;
    RST = 1'b1; MODE = 1'b0; HOLD = 1'b0; SEL = '0;
`ifdef MUX_SCAN_MASK_EN
    CH_MASK = '1;
`endif
    m_ch = 0; m_cnt = 0;

    // Reset and manual select, including clamp boundaries.
    tbl[0] = '{1, 1, 6, 1, 0, 0, 0};
    tbl[1] = '{1, 1, 6, 1, 0, 0, 0};
    tbl[2] = '{0, 0, 0, 0, 0, 1, 0};
    tbl[3] = '{0, 0, 3, 0, 3, 4, 1};
    tbl[4] = '{0, 0, 3, 0, 3, 4, 0};
    tbl[5] = '{0, 0, 7, 0, 4, 5, 1};
    tbl[6] = '{0, 0, 7, 0, 4, 5, 0};
    tbl[7] = '{0, 0, 5, 0, 4, 5, 0};
    tbl[8] = '{0, 0, 4, 0, 4, 5, 0};
    tbl[9] = '{0, 0, 0, 0, 0, 1, 1};
    for (int i = 0; i < 10; i++) begin
      RST = tbl[i].rst; MODE = tbl[i].mode; SEL = SELW'(tbl[i].sel); HOLD = tbl[i].hold;
      cycle("tbl");
      chk_state($sformatf("vec%0d", i), tbl[i].ch, tbl[i].dout, tbl[i].chg);
    end

    // Data change on the selected channel shows one cycle later.
    SEL = 3'd4; cycle("sel4");
    chan[4] = 7; cycle("data");
    chk_state("data7", 4, 7, 0);
    chan[4] = 5;

    // Auto scan from CH=0, then hold two cycles into CH=2.
    SEL = '0; cycle("pre_auto");
    MODE = 1'b1;
    for (int e = 1; e <= 30; e++) begin
      cycle("auto");
      chk_state("scan", (e / 4) % 5, (e / 4) % 5 + 1, (e % 4 == 0) ? 1 : 0);
    end
    HOLD = 1'b1;
    for (int e = 0; e < 10; e++) begin
      cycle("hold");
      chk_state("held", 2, 3, 0);
    end
    HOLD = 1'b0;
    cycle("rel1"); chk_state("rel1", 2, 3, 0);
    cycle("rel2"); chk_state("rel2", 3, 4, 1);
    cycle("mid");
    MODE = 1'b0; SEL = 3'd1;
    cycle("to_man"); chk_state("to_man", 1, 2, 1);

    // Mid-scan reset while CH=3.
    MODE = 1'b1;
    for (int e = 0; e < 9; e++) cycle("to3");
    chk_state("at3", 3, 4, 0);
    RST = 1'b1; cycle("rst"); chk_state("midrst", 0, 0, 0);
    RST = 1'b0;
    for (int e = 1; e <= 4; e++) begin
      cycle("resume");
      chk_state("resume", (e == 4) ? 1 : 0, (e == 4) ? 2 : 1, (e == 4) ? 1 : 0);
    end

`ifdef MUX_SCAN_MASK_EN
    // Masked scan, empty mask, and manual select of a disabled channel.
    MODE = 1'b0; SEL = '0; cycle("mpre");
    CH_MASK = 5'b10101; MODE = 1'b1;
    for (int e = 1; e <= 12; e++) begin
      cycle("mscan");
      chk_state("mscan", (e < 4) ? 0 : (e < 8) ? 2 : (e < 12) ? 4 : 0,
                ((e < 4) ? 0 : (e < 8) ? 2 : (e < 12) ? 4 : 0) + 1,
                (e % 4 == 0) ? 1 : 0);
    end
    CH_MASK = '0;
    for (int e = 0; e < 6; e++) begin
      cycle("mnone");
      chk_state("mnone", 0, 0, 0);
    end
    MODE = 1'b0; SEL = 3'd1; CH_MASK = 5'b11101;
    cycle("mman"); chk_state("mman", 1, 0, 1);
    CH_MASK = '1;
`endif

    // Randomized traffic against the model.
    for (int e = 0; e < 600; e++) begin
      RST  = ($urandom % 40) == 0;
      MODE = ($urandom % 4) != 0;
      HOLD = ($urandom % 5) == 0;
      SEL  = SELW'($urandom_range(7, 0));
      if ($urandom % 6 == 0) chan[$urandom_range(N - 1, 0)] = int'($urandom_range(7, 0));
`ifdef MUX_SCAN_MASK_EN
      if ($urandom % 10 == 0) CH_MASK = N'($urandom);
`endif
      cycle("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux_scan_sel.md
Name: mux_scan_sel

Overview:
- Parametrised successor to the 5:1 x 3-bit switch multiplexer: selects one of N channels, each W bits wide, from a packed input bus.
- Two modes:
  - Manual: the channel comes from the select input.
  - Auto-scan: the block steps through the channels, holding each for DWELL clock cycles.
- Output data and channel indicators are registered. The block drives board LEDs (data on green, channel one-hot on red) from the top-level wrapper.

Parameters:
N, 5, number of channels (>=2)
W, 3, bits per channel (>=1)
DWELL, 50000000, cycles each channel is held in auto mode (>=1; 1 = advance every cycle)
SELW, $clog2(N), width of select/channel index (derived, not overridden)

Ports:
CLK  input  1  system clock, all state on rising edge
RST  input  1  synchronous, active-high reset
DIN  input  N*W  packed channels; channel i = DIN[i*W +: W]
SEL  input  SELW  manual channel select
MODE  input  1  0 = manual, 1 = auto-scan
HOLD  input  1  auto mode: freeze dwell counter and channel
DOUT  output  W  registered data of current channel
CH  output  SELW  current channel index
CH_OH  output  N  one-hot of CH
CHG  output  1  one-cycle pulse, high in the first cycle CH shows a new value

Behaviour:
- Reset (RST=1 at an edge):
  - DOUT=0, CH=0, CH_OH=1 (bit 0 set), CHG=0, dwell counter=0.
  - Reset has priority over all other inputs and aborts a scan mid-dwell.
- Each edge computes ch_next, then registers CH<=ch_next, CH_OH<=onehot(ch_next) and DOUT<=DIN slice[ch_next].
  - CH and DOUT are therefore always consistent in the same cycle.
  - Latency from a DIN or SEL change to DOUT is 1 cycle.
- CHG <= (ch_next != CH).
- Manual (MODE=0):
  - ch_next = SEL when SEL<N, else N-1 (clamp; out-of-range selects the last channel).
  - Dwell counter held at 0.
  - HOLD ignored.
- Auto (MODE=1):
  - Dwell counter counts 0..DWELL-1.
  - When counter==DWELL-1 and HOLD=0: counter<=0 and ch_next = (CH==N-1) ? 0 : CH+1.
  - Otherwise, with HOLD=0: counter increments and ch_next=CH.
  - HOLD=1: counter and CH frozen; DOUT keeps tracking DIN of CH. On release, counting resumes from the frozen value.
- Mode changes:
  - Manual->auto: scan starts from the current CH with counter=0; the first step occurs DWELL cycles after MODE rises.
  - Auto->manual: CH takes the clamped SEL at the next edge; counter cleared.
- Counter width: $clog2(DWELL) bits, minimum 1. DWELL=1 is legal (step every cycle, counter stays 0).

Optional Feature:
- Macro: MUX_SCAN_MASK_EN.
- Defined:
  - Adds input CH_MASK [N-1:0]; 1 = channel enabled.
  - Auto step: ch_next = the first enabled channel in the order CH+1, CH+2, ... wrapping, up to and including CH itself.
  - No channel enabled: CH holds, CHG stays 0, DOUT=0.
  - Manual mode: CH follows the clamped SEL regardless of mask; if that channel is disabled, DOUT=0.
- Undefined: no CH_MASK port; all channels treated as enabled.

Decomposition:
- Package mux_scan_pkg holds:
  - Constants MODE_MANUAL=1'b0, MODE_AUTO=1'b1.
  - Function onehot(idx,N).
  - Function clamp_sel(sel,N).
- One sub-module, scan_tick_gen: dwell counter with en/hold/clear inputs and a tick output (pulse on count DWELL-1 when not held). The top module contains the channel register, mask search and output registers.

Test Plan:
All scenarios use N=5, W=3, DWELL=4, and DIN channels i=0..4 loaded with values i+1.
- Reset: RST=1 for 2 cycles with any inputs -> DOUT=0, CH=0, CH_OH=5'b00001, CHG=0; after release with MODE=0, SEL=0 -> DOUT=1, CHG=0.
- Manual select: SEL=3 -> next edge CH=3, CH_OH=5'b01000, DOUT=4, CHG=1 for exactly 1 cycle. SEL=7 -> CH=4, DOUT=5. Change channel 4 data to 7 -> DOUT=7 one cycle later, CHG=0.
- Auto scan: MODE=1 from CH=0 -> CH sequence 0,1,2,3,4,0 with each value held 4 cycles, CHG pulsing at every step, DOUT=CH+1.
- Hold:
  - HOLD=1 for 10 cycles, asserted 2 cycles into CH=2 -> CH stays 2; after release, CH=3 after the remaining 2 cycles.
  - MODE=0 with SEL=1 mid-dwell -> CH=1 next edge.
- Mid-scan reset: RST=1 while CH=3 in auto mode -> CH=0, DOUT=0, counter 0 at the next edge; scan resumes with the first step 4 cycles after release.
- Mask (MUX_SCAN_MASK_EN defined):
  - CH_MASK=5'b10101 in auto mode -> CH 0,2,4,0.
  - CH_MASK=0 -> CH frozen, CHG=0, DOUT=0.
  - Manual SEL=1 with mask bit 1 clear -> CH=1, DOUT=0.
